// File: rtl/tdm_pkg.sv
// tdm_pkg: state encoding, default sizes and slot wrap shared by both ends of the TDM link
package tdm_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
  // Wrap explicitly at n-1 so non-power-of-two channel counts stay correct
  function automatic int unsigned slot_next(input int unsigned slot, input int unsigned n);
    return (slot == n - 1) ? 0 : slot + 1;
  endfunction
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial TDM input and parallel channel outputs of the demultiplexer
interface tdm_demux_if #(
  parameter int NUM_CH = 4,
  parameter int DW = 8
);
  logic in_valid;
  logic in_sync;
  logic [DW-1:0] in_data;
  logic [NUM_CH*DW-1:0] out_data;
  logic [NUM_CH-1:0] out_valid;
  logic frame_done;
  logic sync_err;
  logic locked;
  modport master (
    output in_valid, in_sync, in_data,
    input out_data, out_valid, frame_done, sync_err, locked
  );
  modport slave (
    input in_valid, in_sync, in_data,
    output out_data, out_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: frame slot counter with clear, load-to-1, wrapping advance and last-slot flag
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SW = $clog2(NUM_CH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load1,
  input  logic adv,
  output logic [SW-1:0] slot,
  output logic last
);
  always_ff @(posedge clk) begin
    if (rst || clr) slot <= '0;
    else if (load1) slot <= SW'(1);
    else if (adv) slot <= SW'(slot_next(32'(slot), NUM_CH));
  end
  assign last = (slot == SW'(NUM_CH - 1));
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: splits a sync-framed serial sample stream into NUM_CH registered channels
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DW = DW_DEF,
  localparam int SW = $clog2(NUM_CH)
) (
  input logic clk,
  input logic rst,
  tdm_demux_if.slave bus
);
  localparam logic [0:0] ST_HUNT = HUNT;
  localparam logic [0:0] ST_LOCKED = LOCKED;
  logic [0:0] state;
  logic [SW-1:0] slot;
  logic last;
  logic start, wr_mid, lose, err_c, wr_en, is_locked;
  logic [SW-1:0] wr_idx;
  logic [NUM_CH*DW-1:0] data;
  logic [NUM_CH-1:0] ov;
  logic fd, err;
  assign is_locked = (state == ST_LOCKED);
  // Any sync sample (re)starts a frame at slot 0, whether hunting or locked
  always_comb begin
    start = bus.in_valid & bus.in_sync;
    wr_mid = bus.in_valid & is_locked & ~bus.in_sync & (slot != '0);
    lose = bus.in_valid & is_locked & ~bus.in_sync & (slot == '0);
    err_c = bus.in_valid & is_locked & ((slot != '0) ? bus.in_sync : ~bus.in_sync);
    wr_en = start | wr_mid;
    wr_idx = start ? '0 : slot;
  end
  tdm_slot_ctr #(.NUM_CH(NUM_CH), .SW(SW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(lose),
    .load1(start),
    .adv(wr_mid),
    .slot(slot),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HUNT;
      data <= '0;
      ov <= '0;
      fd <= 1'b0;
      err <= 1'b0;
    end else begin
      ov <= wr_en ? (NUM_CH'(1) << wr_idx) : '0;
      fd <= wr_mid & last;
      err <= err_c;
      state <= start ? ST_LOCKED : lose ? ST_HUNT : state;
      for (int k = 0; k < NUM_CH; k++)
        if (wr_en && wr_idx == SW'(k)) data[k*DW +: DW] <= bus.in_data;
    end
  end
  assign bus.out_data = data;
  assign bus.out_valid = ov;
  assign bus.frame_done = fd;
  assign bus.sync_err = err;
  assign bus.locked = is_locked;
endmodule
